// File: rtl/move_gen_sched.sv
// rtl/move_gen_sched.sv - board scheduler: launch column units, drain their move FIFOs into one stream
module move_gen_sched #(
    parameter int NCOL        = 8,
    parameter int MOVEW       = 48,
    parameter int RST_CYC     = 2,
    parameter int GEN_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [255:0]            bstate_in,
    output logic [255:0]            bstate_out,
    output logic                    col_reset,
    input  logic [NCOL-1:0]         col_done,
    input  logic [NCOL-1:0]         col_empty,
    input  logic [NCOL*MOVEW-1:0]   col_dout,
    output logic [NCOL-1:0]         col_rden,
    output logic [MOVEW-1:0]        move_out,
    output logic                    move_valid,
    input  logic                    move_ready,
    output logic [7:0]              move_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int CW = $clog2(GEN_TIMEOUT + RST_CYC + 1);
    localparam int NF = MOVEW / 6;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_DRAIN, S_FIN} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    p;
    logic             tail;
    logic [CW-1:0]    cnt;
    logic [MOVEW-1:0] head;
    logic             is_marker;
    logic             out_free;
    logic             advance;
    logic             load;
    logic             last_col;

    assign head     = col_dout[p*MOVEW +: MOVEW];
    assign out_free = !move_valid || move_ready;
    assign last_col = (p == PW'(NCOL-1));

    // A column's end marker is a self-to-self move: every 6-bit field identical.
    always_comb begin
        is_marker = 1'b1;
        for (int k = 1; k < NF; k++) begin
            if (head[6*k +: 6] != head[5:0]) is_marker = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        col_rden  = '0;
        load      = 1'b0;
        advance   = 1'b0;
        col_reset = (state == S_IDLE) || (state == S_LOAD);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (cnt == CW'(RST_CYC-1)) state_nx = S_GEN;
            S_GEN: begin
                if (&col_done)                          state_nx = S_DRAIN;
                else if (cnt == CW'(GEN_TIMEOUT-1))     state_nx = S_FIN;
            end
            S_DRAIN: begin
                if (tail) begin
                    if (out_free) state_nx = S_FIN;
                end else if (col_empty[p]) begin
                    advance = 1'b1;
                end else if (is_marker) begin
                    col_rden[p] = 1'b1;
                    advance     = 1'b1;
                end else if (out_free) begin
                    col_rden[p] = 1'b1;
                    load        = 1'b1;
                end
                // Leaving the last column: finish now if the output register drains this cycle.
                if (advance && last_col && out_free) state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bstate_out <= '0;
            move_out   <= '0;
            move_valid <= 1'b0;
            move_count <= '0;
            error      <= 1'b0;
            cnt        <= '0;
            p          <= '0;
            tail       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bstate_out <= bstate_in;
                        move_count <= '0;
                        error      <= 1'b0;
                        cnt        <= '0;
                        p          <= '0;
                        tail       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (cnt == CW'(RST_CYC-1)) cnt <= '0;
                    else                       cnt <= cnt + 1'b1;
                end
                S_GEN: begin
                    if (!(&col_done)) begin
                        if (cnt == CW'(GEN_TIMEOUT-1)) error <= 1'b1;
                        else                            cnt   <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (advance && !last_col)     p    <= p + 1'b1;
                    else if (advance && !out_free) tail <= 1'b1;
                end
                S_FIN: begin
                    p    <= '0;
                    tail <= 1'b0;
                end
                default: ;
            endcase
            if (load) begin
                move_out   <= head;
                move_valid <= 1'b1;
                if (move_count != 8'hFF) move_count <= move_count + 1'b1;
            end else if (move_valid && move_ready) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_move_gen_sched.sv
// tb/tb_move_gen_sched.sv - self-checking bench for move_gen_sched
module tb_move_gen_sched;

    localparam int NCOL        = 8;
    localparam int MOVEW       = 48;
    localparam int RST_CYC     = 2;
    localparam int GEN_TIMEOUT = 16;
    localparam int DEPTH       = 512;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [255:0]          bstate_in;
    logic [255:0]          bstate_out;
    logic                  col_reset;
    logic [NCOL-1:0]       col_done;
    logic [NCOL-1:0]       col_empty;
    logic [NCOL*MOVEW-1:0] col_dout;
    logic [NCOL-1:0]       col_rden;
    logic [MOVEW-1:0]      move_out;
    logic                  move_valid;
    logic                  move_ready;
    logic [7:0]            move_count;
    logic                  busy;
    logic                  done;
    logic                  error;

    always #5 clk = ~clk;

    move_gen_sched #(
        .NCOL(NCOL), .MOVEW(MOVEW), .RST_CYC(RST_CYC), .GEN_TIMEOUT(GEN_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bstate_in(bstate_in),
        .bstate_out(bstate_out), .col_reset(col_reset), .col_done(col_done),
        .col_empty(col_empty), .col_dout(col_dout), .col_rden(col_rden),
        .move_out(move_out), .move_valid(move_valid), .move_ready(move_ready),
        .move_count(move_count), .busy(busy), .done(done), .error(error)
    );

    typedef struct packed {
        logic [7:0][7:0] nmv;
        logic            mark;
        logic            toggle;
        logic            poke;
        logic [7:0]      exp_cnt;
        logic [7:0]      exp_lat;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [47:0] mem [NCOL][DEPTH];
    int          rd_ptr [NCOL];
    int          wr_ptr [NCOL];
    logic [47:0] exp_q [$];
    int          pops, marker_pops, done_cnt;
    bit          toggle_mode;
    vec_t        tbl [6];

    function automatic bit is_mark(input logic [47:0] w);
        for (int k = 1; k < 8; k++) if (w[6*k +: 6] != w[5:0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NCOL; i++) begin
            col_empty[i] = (rd_ptr[i] == wr_ptr[i]);
            col_dout[i*MOVEW +: MOVEW] = col_empty[i] ? 48'h1234_5678_9ABC : mem[i][rd_ptr[i]];
        end
    endtask

    task automatic step();
        logic [NCOL-1:0] rd;
        logic [47:0]     ew;
        bit              ok;
        @(negedge clk);
        if (move_valid && move_ready) begin
            if (exp_q.size() == 0) chk("move_extra", 256'(move_out), 256'(0));
            else begin
                ew = exp_q.pop_front();
                chk("move_word", 256'(move_out), 256'(ew));
            end
        end
        rd = col_rden;
        if (rd != '0) begin
            ok = $onehot(rd);
            for (int i = 0; i < NCOL; i++) begin
                if (rd[i]) begin
                    if (col_empty[i]) ok = 1'b0;
                    else if (!is_mark(mem[i][rd_ptr[i]]) && move_valid && !move_ready) ok = 1'b0;
                end
            end
            chk("rden_ok", 256'(ok), 256'(1));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCOL; i++) begin
            if (rd[i] && rd_ptr[i] != wr_ptr[i]) begin
                pops++;
                if (is_mark(mem[i][rd_ptr[i]])) marker_pops++;
                rd_ptr[i]++;
            end
        end
        refresh();
        move_ready = toggle_mode ? ~move_ready : 1'b1;
        if (done) done_cnt++;
    endtask

    task automatic load_fifos(input logic [7:0][7:0] nmv, input bit mark);
        logic [47:0] w;
        logic [5:0]  v;
        exp_q.delete();
        for (int c = 0; c < NCOL; c++) begin
            rd_ptr[c] = 0;
            wr_ptr[c] = 0;
            for (int j = 0; j < int'(nmv[c]); j++) begin
                w[47:16] = $urandom;
                w[15:0]  = 16'($urandom);
                w[11:6]  = w[5:0] ^ 6'h1;
                mem[c][wr_ptr[c]] = w;
                wr_ptr[c]++;
                exp_q.push_back(w);
            end
            if (mark) begin
                v = 6'($urandom_range(0, 63));
                mem[c][wr_ptr[c]] = {8{v}};
                wr_ptr[c]++;
            end
        end
        refresh();
        pops = 0;
        marker_pops = 0;
        done_cnt = 0;
    endtask

    task automatic start_board(input logic [255:0] bs);
        bstate_in = bs;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bstate_latch", bstate_out, bs);
        chk("load_col_reset", 256'(col_reset), 256'(1));
        chk("load_busy", 256'(busy), 256'(1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done_cnt == 0 && lat < 2000) begin
            step();
            lat++;
        end
        chk("done_seen", 256'(done_cnt), 256'(1));
    endtask

    task automatic run_board(input vec_t v);
        logic [255:0] bs;
        int           lat, total;
        bs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        total = 0;
        for (int c = 0; c < NCOL; c++) total += int'(v.nmv[c]);
        toggle_mode = v.toggle;
        move_ready  = 1'b1;
        col_done    = '0;
        load_fifos(v.nmv, v.mark);
        start_board(bs);
        repeat (RST_CYC) step();
        chk("gen_col_reset", 256'(col_reset), 256'(0));
        repeat (10) step();
        col_done = '1;
        lat = 0;
        while (done_cnt == 0 && lat < 2000) begin
            step();
            lat++;
            if (v.poke && lat == 6) begin
                bstate_in = ~bs;
                start = 1'b1;
                step();
                lat++;
                start = 1'b0;
            end
        end
        chk("done_seen", 256'(done_cnt), 256'(1));
        if (v.exp_lat != 0) chk("drain_latency", 256'(lat), 256'(v.exp_lat));
        chk("move_count", 256'(move_count), 256'(v.exp_cnt));
        repeat (3) step();
        chk("done_pulse", 256'(done_cnt), 256'(1));
        chk("idle_busy", 256'(busy), 256'(0));
        chk("words_left", 256'(exp_q.size()), 256'(0));
        chk("marker_pops", 256'(marker_pops), 256'(v.mark ? 8 : 0));
        chk("total_pops", 256'(pops), 256'(total + (v.mark ? 8 : 0)));
        if (v.poke) chk("bstate_kept", bstate_out, bs);
        col_done = '0;
    endtask

    initial begin
        int lat;
        logic [7:0][7:0] zero_nmv;
        logic [7:0][7:0] rst_nmv;
        zero_nmv = '0;
        rst_nmv = '0;
        rst_nmv[0] = 8'd20;

        tbl[0] = '{nmv: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0}, mark: 1'b1, toggle: 1'b0, poke: 1'b0, exp_cnt: 8'd3,   exp_lat: 8'd12};
        tbl[1] = '{nmv: {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, mark: 1'b1, toggle: 1'b1, poke: 1'b0, exp_cnt: 8'd5,   exp_lat: 8'd0};
        tbl[2] = '{nmv: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, mark: 1'b0, toggle: 1'b0, poke: 1'b0, exp_cnt: 8'd0,   exp_lat: 8'd9};
        tbl[3] = '{nmv: {8'd0, 8'd0, 8'd4, 8'd0, 8'd1, 8'd0, 8'd2, 8'd0}, mark: 1'b1, toggle: 1'b0, poke: 1'b0, exp_cnt: 8'd7,   exp_lat: 8'd16};
        tbl[4] = '{nmv: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4}, mark: 1'b0, toggle: 1'b0, poke: 1'b0, exp_cnt: 8'd4,   exp_lat: 8'd13};
        tbl[5] = '{nmv: {8'd35, 8'd35, 8'd35, 8'd35, 8'd40, 8'd40, 8'd40, 8'd40}, mark: 1'b1, toggle: 1'b0, poke: 1'b1, exp_cnt: 8'd255, exp_lat: 8'd0};

        reset = 1'b0;
        start = 1'b0;
        bstate_in = '0;
        col_done = '0;
        move_ready = 1'b1;
        toggle_mode = 1'b0;
        load_fifos(zero_nmv, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bstate_out", bstate_out, 256'(0));
        chk("rst_col_reset", 256'(col_reset), 256'(1));
        chk("rst_col_rden", 256'(col_rden), 256'(0));
        chk("rst_move_out", 256'(move_out), 256'(0));
        chk("rst_move_valid", 256'(move_valid), 256'(0));
        chk("rst_move_count", 256'(move_count), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_error", 256'(error), 256'(0));
        reset = 1'b1;
        step();
        chk("idle_after_por", 256'(busy), 256'(0));

        for (int t = 0; t < 6; t++) run_board(tbl[t]);

        // Generation timeout: column 7 never reports done.
        toggle_mode = 1'b0;
        load_fifos(zero_nmv, 1'b0);
        col_done = 8'h7F;
        start_board({8{32'hA5A5_0F0F}});
        repeat (RST_CYC) step();
        pops = 0;
        repeat (GEN_TIMEOUT-1) step();
        chk("to_error_early", 256'(error), 256'(0));
        chk("to_busy_gen", 256'(busy), 256'(1));
        step();
        chk("to_error_set", 256'(error), 256'(1));
        chk("to_done", 256'(done), 256'(1));
        step();
        chk("to_error_sticky", 256'(error), 256'(1));
        chk("to_idle", 256'(busy), 256'(0));
        chk("to_no_pops", 256'(pops), 256'(0));
        col_done = 8'hFF;
        done_cnt = 0;
        start_board({8{32'h5A5A_F0F0}});
        chk("to_error_cleared", 256'(error), 256'(0));
        wait_done(lat);
        chk("to_next_count", 256'(move_count), 256'(0));
        col_done = '0;
        step();

        // Asynchronous reset while a column is streaming out.
        load_fifos(rst_nmv, 1'b1);
        start_board({8{32'h1357_9BDF}});
        repeat (RST_CYC) step();
        col_done = '1;
        repeat (5) step();
        chk("pre_rst_valid", 256'(move_valid), 256'(1));
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(move_valid), 256'(0));
        chk("mid_rst_col_reset", 256'(col_reset), 256'(1));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_rden", 256'(col_rden), 256'(0));
        chk("mid_rst_count", 256'(move_count), 256'(0));
        step();
        reset = 1'b1;
        col_done = '0;
        step();
        chk("post_rst_idle", 256'(busy), 256'(0));
        chk("post_rst_col_reset", 256'(col_reset), 256'(1));
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
